// File: rtl/player_input_ctrl.sv
// Player input front end: synchronizes raw pushbuttons and call switches,
// debounces each button, captures the player's call on a debounced press
// and issues one-cycle press strobes in ascending player order.
module player_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  btn,
  input  logic [17:0] sw_in,
  output logic [2:0]  player1,
  output logic [2:0]  player2,
  output logic [2:0]  player3,
  output logic [2:0]  player4,
  output logic [2:0]  player5,
  output logic [2:0]  player6,
  output logic [5:0]  player_clk
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [5:0]       btn_s1_q, btn_s1_d;
  logic [5:0]       btn_s2_q, btn_s2_d;
  logic [17:0]      sw_s1_q, sw_s1_d;
  logic [17:0]      sw_s2_q, sw_s2_d;
  logic [5:0]       deb_q, deb_d;
  logic [5:0]       deb_dly_q, deb_dly_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic [2:0]       call_q [6];
  logic [2:0]       call_d [6];
  logic [5:0]       pending_q, pending_d;
  logic [5:0]       player_clk_q, player_clk_d;
  logic [5:0]       accept;
  logic [5:0]       grant;

  // Next-state: synchronizers, debounce counters, call capture, strobe arbiter
  always_comb begin
    btn_s1_d  = btn;
    btn_s2_d  = btn_s1_q;
    sw_s1_d   = sw_in;
    sw_s2_d   = sw_s1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = cnt_q;
    call_d    = call_q;

    for (int unsigned i = 0; i < 6; i++) begin
      if (btn_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end

    // Only rising debounced edges are presses; falling edges are ignored.
    accept = deb_q & ~deb_dly_q;
    for (int unsigned i = 0; i < 6; i++) begin
      if (accept[i]) call_d[i] = sw_s2_q[3*i +: 3];
    end

    // Two's-complement trick isolates the lowest set pending bit.
    grant        = pending_q & (~pending_q + 6'd1);
    player_clk_d = grant;
    pending_d    = (pending_q & ~grant) | accept;
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      deb_q        <= '0;
      deb_dly_q    <= '0;
      pending_q    <= '0;
      player_clk_q <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        cnt_q[i]  <= '0;
        call_q[i] <= '0;
      end
    end else begin
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      sw_s1_q      <= sw_s1_d;
      sw_s2_q      <= sw_s2_d;
      deb_q        <= deb_d;
      deb_dly_q    <= deb_dly_d;
      pending_q    <= pending_d;
      player_clk_q <= player_clk_d;
      for (int unsigned i = 0; i < 6; i++) begin
        cnt_q[i]  <= cnt_d[i];
        call_q[i] <= call_d[i];
      end
    end
  end

  assign player1    = call_q[0];
  assign player2    = call_q[1];
  assign player3    = call_q[2];
  assign player4    = call_q[3];
  assign player5    = call_q[4];
  assign player6    = call_q[5];
  assign player_clk = player_clk_q;

endmodule

// File: doc/player_input_ctrl.md
PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive clk cycles a synchronized button level must differ from the debounced level before the debounced level toggles; legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 20: debounce counter width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 btn  input  6  raw asynchronous pushbuttons, active-high; btn[i] belongs to player i+1.
REQ-006 sw_in  input  18  raw asynchronous call switches; sw_in[3i+2:3i] is player i+1's 3-bit call.
REQ-007 player1..player6  output  3 each  registered call of each player, feeding the game block's player inputs.
REQ-008 player_clk  output  6  registered press strobes, one bit per player, feeding the game block's player_clk.

Function
REQ-009 Each btn bit and each sw_in bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-010 Per player: counter increments on each edge where s2 differs from debounced level deb; clears to 0 on any edge where they are equal.
REQ-011 On the edge where counter equals DEBOUNCE_CYCLES-1 and s2 still differs, deb SHALL toggle and counter clear.
REQ-012 A press SHALL be accepted on the edge after deb goes 0->1 (deb=1, deb_d=0); deb 1->0 transitions SHALL produce no action.
REQ-013 On acceptance of player i, the s2 value of that player's switches SHALL be captured into player(i+1), and pending[i] set, on the same edge.
REQ-014 player(i+1) SHALL hold its value until that player's next accepted press; switch changes otherwise have no effect.
REQ-015 Each edge, player_clk SHALL be loaded with a one-hot copy of the lowest-index set pending bit (or 0 if none), and that pending bit cleared on the same edge.
REQ-016 At most one player_clk bit SHALL be high in any cycle; each strobe SHALL be high for exactly one clk cycle.
REQ-017 Latency, uncontended: btn stable high first sampled at edge t0 -> player(i+1) updated at edge t0+DEBOUNCE_CYCLES+2 -> player_clk[i] high from edge t0+DEBOUNCE_CYCLES+3 for one cycle.
REQ-018 The call value SHALL therefore be stable at least one full cycle before its strobe rises.
REQ-019 Simultaneous acceptances: strobes issue in ascending player index on consecutive cycles; the k-th (0-based) issues k cycles after the uncontended time.
REQ-020 A press accepted while the same player's pending bit is still set SHALL overwrite player(i+1) and leave a single pending bit (coalesced; one strobe).
REQ-021 Button pulses shorter than DEBOUNCE_CYCLES synchronized cycles, and any bounce during a held press, SHALL produce no strobe.
REQ-022 A button held indefinitely SHALL produce exactly one strobe.

Reset
REQ-023 reset_n low SHALL immediately clear synchronizers, deb, deb_d, counters, pending, player_clk and player1..player6 to 0, independent of clk.
REQ-024 Reset asserted mid-debounce or with pending bits set SHALL discard them; no strobe issues for them after release.
REQ-025 A button already high at reset release SHALL be treated as a new press and strobe once after REQ-017 latency.

Verification
REQ-026 Reset: reset_n=0 with random btn/sw_in -> all outputs 0 while low and until first accepted press.
REQ-027 Clean press, DEBOUNCE_CYCLES=4: sw_in[2:0]=3'b010, btn[0] high from t0 -> player1=3'b010 after edge t0+6, player_clk=6'b000001 for exactly the cycle after edge t0+7, then 6'b000000.
REQ-028 Bounce: btn[1] high 3 cycles then low, repeated 5 times -> player_clk stays 6'b000000, player2 stays 3'b000.
REQ-029 Simultaneous: btn[3] and btn[1] rise same cycle with calls 3'b011 and 3'b001 -> player_clk=6'b000010 one cycle, then 6'b001000 next cycle; player2=3'b001, player4=3'b011.
REQ-030 Reset mid-operation: reset_n pulsed low between acceptance and strobe of btn[2] -> player3=3'b000, no strobe after release while btn[2] low.
REQ-031 Hold and switch change: btn[4] held 100 cycles, sw for player5 changed 3'b001->3'b100 after strobe -> exactly one 6'b010000 strobe, player5 remains 3'b001.
